joypad_serializer: RTL and testbench

Parametrised multi-port replacement for the inline joypad shift logic in the NES top-level bench. It models N controller ports, each latching a BITS-wide button word on strobe and shifting it out LSB-first on falling edges of that port's joypad_clock. It adds three things the inline logic lacks: a configurable post-read fill value, a per-button turbo auto-fire mode driven by a frame tick, and a per-port read-count/overrun status. It sits between the NES core's joypad_strobe/joypad_clock/joypad_data pins and the host-supplied button words.

---
 rtl/joypad_serializer.sv | 99 +++++++++
 tb/tb_joypad_serializer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/joypad_serializer.sv
// joypad_serializer: multi-port NES-style controller shift registers.
// Each port latches a button word on strobe and shifts it out LSB-first on
// falling edges of its own joypad_clock. Adds a post-read fill value, a
// frame-driven turbo auto-fire mask and per-port read-count/overrun status.
module joypad_serializer #(
  parameter int NUM_PORTS    = 2,
  parameter int BITS         = 8,
  parameter int FILL         = 1,
  parameter int TURBO_FRAMES = 2,
  parameter int CW           = $clog2(BITS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      joypad_strobe,
  input  logic [NUM_PORTS-1:0]      joypad_clock,
  input  logic [NUM_PORTS*BITS-1:0] buttons,
  input  logic [NUM_PORTS*BITS-1:0] turbo_mask,
  input  logic                      frame_tick,
  output logic [NUM_PORTS-1:0]      joypad_data,
  output logic [NUM_PORTS*CW-1:0]   read_count,
  output logic [NUM_PORTS-1:0]      overrun
);

  // Turbo frame counter is at least one bit wide even when TURBO_FRAMES is 1.
  localparam int TW = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;
  localparam logic FILL_BIT = (FILL != 0);

  logic [NUM_PORTS-1:0][BITS-1:0] r_sr;
  logic [NUM_PORTS-1:0][CW-1:0]   r_count;
  logic [NUM_PORTS-1:0]           r_overrun;
  logic [NUM_PORTS-1:0]           r_last_clock;
  logic [TW-1:0]                  r_turbo_cnt;
  logic                           r_turbo_phase;

  logic [NUM_PORTS-1:0][BITS-1:0] w_eff;
  logic [NUM_PORTS-1:0]           w_fall;

  assign w_fall = r_last_clock & ~joypad_clock;

  // Effective button word: turbo buttons are masked off during phase 0.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_eff[p] = buttons[p*BITS +: BITS]
               & ~(turbo_mask[p*BITS +: BITS] & {BITS{~r_turbo_phase}});
    end
  end

  // Turbo phase generator: toggles every TURBO_FRAMES frame ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_turbo_cnt   <= '0;
      r_turbo_phase <= 1'b0;
    end else if (ce && frame_tick) begin
      if (r_turbo_cnt == TW'(TURBO_FRAMES - 1)) begin
        r_turbo_cnt   <= '0;
        r_turbo_phase <= ~r_turbo_phase;
      end else begin
        r_turbo_cnt <= r_turbo_cnt + TW'(1);
      end
    end
  end

  // Per-port shift registers: strobe load wins over a falling read clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr         <= '0;
      r_count      <= '0;
      r_overrun    <= '0;
      r_last_clock <= '0;
    end else if (ce) begin
      r_last_clock <= joypad_clock;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (joypad_strobe) begin
          r_sr[p]      <= w_eff[p];
          r_count[p]   <= '0;
          r_overrun[p] <= 1'b0;
        end else if (w_fall[p]) begin
          r_sr[p] <= {FILL_BIT, r_sr[p][BITS-1:1]};
          if (r_count[p] < CW'(BITS)) begin
            r_count[p] <= r_count[p] + CW'(1);
          end else begin
            r_overrun[p] <= 1'b1;
          end
        end
      end
    end
  end

  // Flatten per-port registers onto the output buses.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      joypad_data[p]          = r_sr[p][0];
      read_count[p*CW +: CW]  = r_count[p];
      overrun[p]              = r_overrun[p];
    end
  end

endmodule

// File: tb/tb_joypad_serializer.sv
// tb_joypad_serializer: table vectors, hand-written corner sequences and a
// randomized run against a behavioural model of the two-port, 8-bit pad.
module tb_joypad_serializer;

  localparam int NP  = 2;
  localparam int NB  = 8;
  localparam int TF  = 2;
  localparam int CWT = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            ce;
  logic            joypadStrobe;
  logic [NP-1:0]   joypadClock;
  logic [NP*NB-1:0] buttons;
  logic [NP*NB-1:0] turboMask;
  logic            frameTick;
  logic [NP-1:0]   joypadData;
  logic [NP*CWT-1:0] readCount;
  logic [NP-1:0]   overrun;

  int checks = 0;
  int errors = 0;

  // Behavioural model: the latched word and how many shifts happened since.
  logic [NB-1:0] mWord [NP];
  int            mShifts [NP];
  logic [NP-1:0] mLast;
  int            mTicks;

  typedef struct packed {
    logic        strobe;
    logic [1:0]  jc;
    logic [15:0] btn;
    logic [1:0]  expData;
    logic [7:0]  expCount;
    logic [1:0]  expOvr;
  } vec_t;

  vec_t vecs[$];

  joypad_serializer #(
    .NUM_PORTS(NP), .BITS(NB), .FILL(1), .TURBO_FRAMES(TF), .CW(CWT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ce(ce),
    .joypad_strobe(joypadStrobe),
    .joypad_clock(joypadClock),
    .buttons(buttons),
    .turbo_mask(turboMask),
    .frame_tick(frameTick),
    .joypad_data(joypadData),
    .read_count(readCount),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic modelStep();
    bit phase;
    phase = ((mTicks / TF) % 2) == 1;
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        mWord[p] = '0;
        mShifts[p] = 0;
      end
      mLast = '0;
      mTicks = 0;
    end else if (ce) begin
      for (int p = 0; p < NP; p++) begin
        if (joypadStrobe) begin
          mWord[p] = buttons[p*NB +: NB] & ~(phase ? '0 : turboMask[p*NB +: NB]);
          mShifts[p] = 0;
        end else if (mLast[p] && !joypadClock[p]) begin
          mShifts[p] = mShifts[p] + 1;
        end
      end
      mLast = joypadClock;
      if (frameTick) mTicks = mTicks + 1;
    end
  endtask

  function automatic logic [NP-1:0] modelData();
    logic [NP-1:0] d;
    for (int p = 0; p < NP; p++) d[p] = (mShifts[p] < NB) ? mWord[p][mShifts[p]] : 1'b1;
    return d;
  endfunction

  function automatic logic [NP*CWT-1:0] modelCount();
    logic [NP*CWT-1:0] c;
    for (int p = 0; p < NP; p++) c[p*CWT +: CWT] = CWT'((mShifts[p] > NB) ? NB : mShifts[p]);
    return c;
  endfunction

  function automatic logic [NP-1:0] modelOverrun();
    logic [NP-1:0] o;
    for (int p = 0; p < NP; p++) o[p] = (mShifts[p] > NB);
    return o;
  endfunction

  task automatic applyStimulus(input logic rst, input logic en, input logic strobe,
                               input logic [1:0] jc, input logic [15:0] btn,
                               input logic [15:0] mask, input logic ft);
    reset = rst;
    ce = en;
    joypadStrobe = strobe;
    joypadClock = jc;
    buttons = btn;
    turboMask = mask;
    frameTick = ft;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] eD,
                             input logic [7:0] eC, input logic [1:0] eO);
    checks++;
    if (joypadData !== eD) begin
      errors++;
      $display("[TB] FAIL %s joypad_data got %b expected %b", name, joypadData, eD);
    end
    checks++;
    if (readCount !== eC) begin
      errors++;
      $display("[TB] FAIL %s read_count got %h expected %h", name, readCount, eC);
    end
    checks++;
    if (overrun !== eO) begin
      errors++;
      $display("[TB] FAIL %s overrun got %b expected %b", name, overrun, eO);
    end
  endtask

  task automatic addVec(input logic s, input logic [1:0] jc, input logic [15:0] b,
                        input logic [1:0] d, input logic [7:0] c, input logic [1:0] o);
    vec_t v;
    v.strobe = s; v.jc = jc; v.btn = b;
    v.expData = d; v.expCount = c; v.expOvr = o;
    vecs.push_back(v);
  endtask

  initial begin
    int expBit [11] = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 1};
    int turboPat [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    logic [3:0] cnt;

    // Reset held with both read clocks high, then idle without shifting.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 2'b11, 16'h00A5, 16'h0000, 0);
      checkOutput("reset", 2'b00, 8'h00, 2'b00);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 0, 2'b11, 16'h00A5, 16'h0000, 0);
      checkOutput("idle", 2'b00, 8'h00, 2'b00);
    end

    // Basic read of 8'hA5 on port 0, overrun past 8 reads, strobe priority.
    addVec(1, 2'b11, 16'h00A5, 2'b01, 8'h00, 2'b00);
    for (int k = 1; k <= 10; k++) begin
      cnt = 4'((k > 8) ? 8 : k);
      addVec(0, 2'b10, 16'h00A5, {1'b0, 1'(expBit[k])}, {4'h0, cnt}, {1'b0, 1'(k > 8)});
      addVec(0, 2'b11, 16'h00A5, {1'b0, 1'(expBit[k])}, {4'h0, cnt}, {1'b0, 1'(k > 8)});
    end
    addVec(1, 2'b11, 16'h00A5, 2'b01, 8'h00, 2'b00);
    addVec(1, 2'b11, 16'h01A5, 2'b11, 8'h00, 2'b00);
    addVec(1, 2'b01, 16'h01A5, 2'b11, 8'h00, 2'b00);
    addVec(1, 2'b11, 16'h00A5, 2'b01, 8'h00, 2'b00);
    addVec(1, 2'b01, 16'h00A5, 2'b01, 8'h00, 2'b00);
    addVec(0, 2'b11, 16'h00A5, 2'b01, 8'h00, 2'b00);
    foreach (vecs[i]) begin
      applyStimulus(0, 1, vecs[i].strobe, vecs[i].jc, vecs[i].btn, 16'h0000, 0);
      checkOutput($sformatf("vec%0d", i), vecs[i].expData, vecs[i].expCount, vecs[i].expOvr);
    end

    // Turbo: one strobe, one read and one frame tick per frame.
    applyStimulus(1, 1, 0, 2'b11, 16'h0000, 16'h0000, 0);
    for (int f = 0; f < 8; f++) begin
      applyStimulus(0, 1, 1, 2'b11, 16'h0003, 16'h0001, 0);
      checkOutput($sformatf("turboLoad%0d", f), {1'b0, 1'(turboPat[f])}, 8'h00, 2'b00);
      applyStimulus(0, 1, 0, 2'b10, 16'h0003, 16'h0001, 0);
      checkOutput($sformatf("turboBit1_%0d", f), 2'b01, 8'h01, 2'b00);
      applyStimulus(0, 1, 0, 2'b11, 16'h0003, 16'h0001, 1);
    end

    // Clock-enable gating: edges under ce low neither shift nor get lost.
    applyStimulus(0, 1, 1, 2'b11, 16'h00A5, 16'h0000, 0);
    checkOutput("ceLoad", 2'b01, 8'h00, 2'b00);
    applyStimulus(0, 0, 0, 2'b10, 16'h00A5, 16'h0000, 0);
    checkOutput("ceLowFall", 2'b01, 8'h00, 2'b00);
    applyStimulus(0, 0, 0, 2'b11, 16'h00A5, 16'h0000, 0);
    applyStimulus(0, 1, 0, 2'b11, 16'h00A5, 16'h0000, 0);
    checkOutput("ceHighHigh", 2'b01, 8'h00, 2'b00);
    applyStimulus(0, 1, 0, 2'b10, 16'h00A5, 16'h0000, 0);
    checkOutput("ceShift1", 2'b00, 8'h01, 2'b00);
    applyStimulus(0, 1, 0, 2'b10, 16'h00A5, 16'h0000, 0);
    checkOutput("ceHoldLow", 2'b00, 8'h01, 2'b00);
    applyStimulus(0, 1, 0, 2'b11, 16'h00A5, 16'h0000, 0);
    applyStimulus(0, 0, 0, 2'b10, 16'h00A5, 16'h0000, 0);
    checkOutput("ceGapFall", 2'b00, 8'h01, 2'b00);
    applyStimulus(0, 1, 0, 2'b10, 16'h00A5, 16'h0000, 0);
    checkOutput("ceFallKept", 2'b01, 8'h02, 2'b00);

    // Reset in the middle of a read aborts it.
    applyStimulus(1, 1, 0, 2'b10, 16'h00A5, 16'h0000, 0);
    checkOutput("midReset", 2'b00, 8'h00, 2'b00);
    applyStimulus(0, 1, 0, 2'b11, 16'h00A5, 16'h0000, 0);
    checkOutput("postReset", 2'b00, 8'h00, 2'b00);

    // Randomized traffic against the behavioural model.
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 7) != 0),
                    1'($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
                    16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) == 0));
      checkOutput($sformatf("rand%0d", i), modelData(), modelCount(), modelOverrun());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
